// File: rtl/mcht_tx_sched.sv
// Round-robin scheduler sharing one Manchester TRX between pNUM_REQ requesters.
// Launches the granted message, optionally waits for a reply with timeout, then enforces an inter-frame gap.
`timescale 1ns/1ps
module mcht_tx_sched #(
  parameter int unsigned pNUM_REQ = 4,
  parameter int unsigned pMSG_LEN = 16,
  parameter int unsigned pIFG_CYC = 8,
  parameter int unsigned pTO_CYC  = 1024
) (
  input  logic                         CLK_25M,
  input  logic                         RST,
  input  logic [pNUM_REQ-1:0]          REQ_VLD,
  input  logic [pNUM_REQ*pMSG_LEN-1:0] REQ_MSG,
  input  logic [pNUM_REQ-1:0]          REQ_RSP,
  output logic [pNUM_REQ-1:0]          REQ_ACK,
  output logic [pNUM_REQ-1:0]          REQ_DNE,
  output logic [pNUM_REQ-1:0]          REQ_TOUT,
  output logic [pMSG_LEN-1:0]          RSP_MSG,
  output logic                         ENC_VLD,
  output logic [pMSG_LEN-1:0]          ENC_MSG,
  input  logic                         ENC_DNE,
  input  logic                         DEC_VLD,
  input  logic [pMSG_LEN-1:0]          DEC_MSG,
  output logic                         BUSY
);

  localparam int unsigned PTR_W   = (pNUM_REQ > 1) ? $clog2(pNUM_REQ) : 1;
  localparam int unsigned CNT_MAX = (pTO_CYC > pIFG_CYC) ? pTO_CYC : pIFG_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [pNUM_REQ-1:0] ONE_HOT0 = pNUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_TX, S_RSP_WAIT, S_GAP
  } state_t;

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    ptr, ptr_nxt;
  logic [PTR_W-1:0]    gnt, gnt_nxt;
  logic                rsp_flag, rsp_flag_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [pMSG_LEN-1:0] enc_msg_q, enc_msg_nxt;
  logic [pMSG_LEN-1:0] rsp_msg_q, rsp_msg_nxt;
  logic [pNUM_REQ-1:0] dne_q, tout_q;
  logic                dne_set, tout_set;

  logic [pMSG_LEN-1:0] req_msg_a [pNUM_REQ];
  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    cand;
  logic [pNUM_REQ-1:0] gnt_oh;

  always_comb begin
    for (int unsigned i = 0; i < pNUM_REQ; i++) begin
      req_msg_a[i] = REQ_MSG[i*pMSG_LEN +: pMSG_LEN];
    end
  end

  // First requester at or after ptr, wrapping around
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < pNUM_REQ; i++) begin
      cand = PTR_W'((32'(ptr) + i) % pNUM_REQ);
      if (!win_found && REQ_VLD[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign gnt_oh = ONE_HOT0 << gnt;

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    gnt_nxt      = gnt;
    rsp_flag_nxt = rsp_flag;
    cnt_nxt      = cnt;
    enc_msg_nxt  = enc_msg_q;
    rsp_msg_nxt  = rsp_msg_q;
    dne_set      = 1'b0;
    tout_set     = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          enc_msg_nxt  = req_msg_a[win_idx];
          rsp_flag_nxt = REQ_RSP[win_idx];
          gnt_nxt      = win_idx;
          ptr_nxt      = PTR_W'((32'(win_idx) + 1) % pNUM_REQ);
          state_nxt    = S_LAUNCH;
        end
      end
      S_LAUNCH: state_nxt = S_TX;
      S_TX: begin
        if (ENC_DNE) begin
          cnt_nxt = '0;
          if (rsp_flag) begin
            state_nxt = S_RSP_WAIT;
          end else begin
            dne_set   = 1'b1;
            state_nxt = S_GAP;
          end
        end
      end
      // A reply on the final timeout cycle takes priority over the timeout
      S_RSP_WAIT: begin
        if (DEC_VLD) begin
          rsp_msg_nxt = DEC_MSG;
          dne_set     = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = S_GAP;
        end else if (cnt == CNT_W'(pTO_CYC - 1)) begin
          tout_set  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_GAP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == CNT_W'(pIFG_CYC - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_25M or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      rsp_flag  <= 1'b0;
      cnt       <= '0;
      enc_msg_q <= '0;
      rsp_msg_q <= '0;
      dne_q     <= '0;
      tout_q    <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      rsp_flag  <= rsp_flag_nxt;
      cnt       <= cnt_nxt;
      enc_msg_q <= enc_msg_nxt;
      rsp_msg_q <= rsp_msg_nxt;
      dne_q     <= dne_set  ? gnt_oh : '0;
      tout_q    <= tout_set ? gnt_oh : '0;
    end
  end

  // Outputs decoded from registered state only
  assign ENC_VLD  = (state == S_LAUNCH);
  assign REQ_ACK  = (state == S_LAUNCH) ? gnt_oh : '0;
  assign BUSY     = (state != S_IDLE);
  assign ENC_MSG  = enc_msg_q;
  assign RSP_MSG  = rsp_msg_q;
  assign REQ_DNE  = dne_q;
  assign REQ_TOUT = tout_q;

endmodule

// File: doc/mcht_tx_sched.md
Name: mcht_tx_sched

Overview:
- Round-robin scheduler that shares one Manchester encoder/decoder pair (MCHT_ENC/MCHT_DEC via MCHT_TRX) between pNUM_REQ requesters.
- Grants one requester at a time and launches its message on the encoder.
- Optionally waits for a decoder reply, with a timeout, and routes the reply back to the granted requester.
- Enforces an inter-frame gap between transmissions. Sits between local command sources and the TRX in the CLK_25M domain.

Parameters:
pNUM_REQ, 4, number of requesters (2..8)
pMSG_LEN, 16, message width, must equal TRX pTX_MSG_LEN and pRX_MSG_LEN
pIFG_CYC, 8, idle gap cycles after each transaction (>=1)
pTO_CYC, 1024, reply timeout in cycles (>=2)

Ports:
CLK_25M  in  1  system clock
RST  in  1  asynchronous active-high reset
REQ_VLD  in  pNUM_REQ  per-requester request, held until REQ_ACK
REQ_MSG  in  pNUM_REQ*pMSG_LEN  message of requester i at [i*pMSG_LEN +: pMSG_LEN]
REQ_RSP  in  pNUM_REQ  requester expects reply; sampled with REQ_MSG at grant
REQ_ACK  out  pNUM_REQ  one-cycle pulse: message accepted
REQ_DNE  out  pNUM_REQ  one-cycle pulse: transaction complete (reply valid if requested)
REQ_TOUT  out  pNUM_REQ  one-cycle pulse: reply timeout
RSP_MSG  out  pMSG_LEN  last received reply, valid with REQ_DNE
ENC_VLD  out  1  to TRX TX_VLD, one-cycle start pulse
ENC_MSG  out  pMSG_LEN  to TRX TX_MSG, held stable from ENC_VLD through ENC_DNE
ENC_DNE  in  1  from TRX TX_DNE
DEC_VLD  in  1  from TRX RX_VLD
DEC_MSG  in  pMSG_LEN  from TRX RX_MSG
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset (async, RST=1):
  - State IDLE, round-robin pointer PTR=0, gap and timeout counters 0.
  - All pulse outputs 0, ENC_MSG=0, RSP_MSG=0, BUSY=0.
  - RST asserted mid-transaction aborts immediately: no REQ_DNE or REQ_TOUT is issued.
- State machine: IDLE, LAUNCH, TX, RSP_WAIT, GAP. All outputs are registered or decoded from state registers; there are no combinational paths from inputs to outputs.
- IDLE:
  - If any REQ_VLD bit is set, the winner W is the first set bit searching PTR, PTR+1, ... mod pNUM_REQ.
  - On that edge: latch ENC_MSG<=REQ_MSG[W], latch the reply flag <=REQ_RSP[W], store W, set PTR<=(W+1) mod pNUM_REQ, go to LAUNCH.
  - With no request, remain in IDLE.
- LAUNCH (exactly 1 cycle):
  - ENC_VLD=1 and REQ_ACK[W]=1; then go to TX.
  - Latency: REQ_VLD sampled high at edge k gives ACK/ENC_VLD high in cycle k+1.
- TX:
  - Wait for ENC_DNE=1.
  - Without the reply flag: REQ_DNE[W] pulses the next cycle, then GAP.
  - With the reply flag: go to RSP_WAIT with the timeout counter cleared.
- RSP_WAIT:
  - The counter increments each cycle.
  - DEC_VLD=1: RSP_MSG<=DEC_MSG, REQ_DNE[W] pulses the next cycle, then GAP.
  - Counter reaches pTO_CYC-1 without DEC_VLD: REQ_TOUT[W] pulses the next cycle, RSP_MSG unchanged, then GAP.
  - DEC_VLD on the final timeout cycle counts as a reply: DONE wins over TOUT.
- GAP:
  - Count pIFG_CYC cycles, then IDLE. The first arbitration is possible in the IDLE cycle that follows.
  - Requests arriving during GAP are held, not lost.
- Ignored inputs and edge cases:
  - ENC_DNE outside TX is ignored.
  - DEC_VLD outside RSP_WAIT is ignored (stray/late replies dropped, RSP_MSG unchanged).
  - A requester dropping REQ_VLD before its ACK withdraws the request; no side effects.
  - REQ_VLD[W] still high after ACK is treated as a new request in a later arbitration.
- Invariants: at most one bit of REQ_ACK/REQ_DNE/REQ_TOUT is set in any cycle, and exactly one of DNE or TOUT follows each ACK (absent reset).
- Fairness: with all requesters continuously asserting, grants rotate 0,1,2,...,pNUM_REQ-1,0.

Test Plan:
(Defaults pNUM_REQ=4, pMSG_LEN=16, pIFG_CYC=8; pTO_CYC=64 for tests.)
1. Single request, REQ_VLD=4'b0010, REQ_MSG[1]=16'hA5C3, REQ_RSP=0; ENC_DNE returned 40 cycles after ENC_VLD -> REQ_ACK=4'b0010 and ENC_VLD together one cycle after request, ENC_MSG=16'hA5C3 held, REQ_DNE=4'b0010 one cycle after ENC_DNE, BUSY low 8 cycles later.
2. All four requesting continuously, no reply -> ACK order 0,1,2,3,0,1; never two ACKs within one transaction.
3. Requester 2 with REQ_RSP=1; DEC_VLD with DEC_MSG=16'h1234 20 cycles after ENC_DNE -> RSP_MSG=16'h1234, REQ_DNE=4'b0100, REQ_TOUT stays 0.
4. Requester 3 with REQ_RSP=1, no DEC_VLD -> REQ_TOUT=4'b1000 exactly 64 cycles after ENC_DNE handling; RSP_MSG unchanged; DEC_VLD on the last timeout cycle gives REQ_DNE instead.
5. Stray DEC_VLD in IDLE/TX/GAP and stray ENC_DNE in IDLE -> no state change, RSP_MSG unchanged, no pulses.
6. RST pulsed during RSP_WAIT -> all outputs 0 immediately, PTR=0; next request from requester 0 granted normally, no DNE/TOUT for the aborted one.
